// File: rtl/uart_io.sv
// Memory-mapped UART: TX FIFO + serialiser, programmable divisor, registered irq.
// Define UART_IO_RX_EN to add the rx port and the single-byte receiver.
`timescale 1ns/1ps
module uart_io #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
`ifdef UART_IO_RX_EN
  ,
  input  logic        rx
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd4) ? 16'd4 : v;
  endfunction

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  logic wr_en, wr_data, wr_status, wr_div;
  assign wr_en     = sel & |wmask;
  assign wr_data   = wr_en && (addr == 2'd0);
  assign wr_status = wr_en && (addr == 2'd1);
  assign wr_div    = wr_en && (addr == 2'd2);

  logic [15:0] div_q;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, fifo_cnt;
  logic fifo_empty, fifo_full, tx_pop, push_ok;
  logic tx_ovf_q, tx_ovf_d, irq_q, irq_d, tx_busy;
  logic rx_valid, rx_ovr, rx_ferr;
  logic [7:0] rx_byte;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_cnt   = wptr_q - rptr_q;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = wr_data && (!fifo_full || tx_pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr_q[AW-1:0]] <= wdata[7:0];
  end

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d, bdiv_q, bdiv_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d, bit_end;

  assign bit_end = (baud_q == bdiv_q - 16'd1);
  assign tx_busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bdiv_d  = bdiv_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    tx_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          tx_pop  = 1'b1;
          sh_d    = fifo_mem[rptr_q[AW-1:0]];
          bdiv_d  = div_q;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        baud_d  = '0;
        bdiv_d  = div_q;
        tx_d    = sh_q[0];
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        baud_d = '0;
        bdiv_d = div_q;
        if (bit_q == 3'd7) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
          bit_d = bit_q + 3'd1;
        end
      end
      STOP: if (bit_end) begin
        baud_d = '0;
        bdiv_d = div_q;
        if (!fifo_empty) begin
          tx_pop  = 1'b1;
          sh_d    = fifo_mem[rptr_q[AW-1:0]];
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_ovf_d = tx_ovf_q & ~(wr_status & wdata[2]);
    if (wr_data && fifo_full && !tx_pop) tx_ovf_d = 1'b1;
    irq_d = (fifo_empty & ~tx_busy) | rx_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bdiv_q   <= DIV_RST;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wptr_q   <= '0;
      rptr_q   <= '0;
      div_q    <= DIV_RST;
      tx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bdiv_q   <= bdiv_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wptr_q   <= wptr_q + PW'(push_ok);
      rptr_q   <= rptr_q + PW'(tx_pop);
      if (wr_div) div_q <= clamp_div(wdata[15:0]);
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) sh_q <= sh_d;

  assign tx  = tx_q;
  assign irq = irq_q;

`ifdef UART_IO_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic        rx_load, rx_bad, rd_data, rx_keep;

  assign rd_data = sel & rstrb & (addr == 2'd0);
  // A byte read in the same cycle frees the holding register for the new byte.
  assign rx_keep = rx_valid_q & ~rd_data;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_load    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_sync_q) begin
          rx_div_d   = div_q;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == rx_div_q - 16'd1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_cnt_q == rx_div_q - 16'd1) begin
        rx_cnt_d   = '0;
        rx_load    = rx_sync_q;
        rx_bad     = ~rx_sync_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d = rx_keep | rx_load;
    rx_ovr_d   = (rx_ovr_q & ~(wr_status & wdata[4])) | (rx_load & rx_keep);
    rx_ferr_d  = (rx_ferr_q & ~(wr_status & wdata[5])) | rx_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RST;
      rx_bit_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh_q <= rx_sh_d;
    if (rx_load && !rx_keep) rx_data_q <= rx_sh_q;
  end

  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_byte  = rx_data_q;

  logic unused_ok;
  assign unused_ok = ^wdata[31:16];
`else
  assign rx_valid = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_ferr  = 1'b0;
  assign rx_byte  = 8'h00;

  logic unused_ok;
  assign unused_ok = ^{wdata[31:16], rstrb};
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = {24'b0, rx_byte};
      2'd1: rdata = {22'b0, fifo_full, 3'b0, rx_ferr, rx_ovr, rx_valid, tx_ovf_q, tx_busy, fifo_empty};
      2'd2: rdata = {16'b0, div_q};
      2'd3: rdata = {16'b0, 7'b0, rx_valid, 8'(fifo_cnt)};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io (FIFO_DEPTH=4); receiver steps run when UART_IO_RX_EN is defined.
`timescale 1ns/1ps
module tb_uart_io;
  logic        clk = 1'b0;
  logic        reset, sel, rstrb, tx, irq;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wmask;
`ifdef UART_IO_RX_EN
  logic        rx;
`endif
  int total = 0;
  int bad   = 0;
  logic [7:0] fb [8];

  always #5 clk = ~clk;

  uart_io #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rstrb(rstrb), .rdata(rdata), .tx(tx), .irq(irq)
`ifdef UART_IO_RX_EN
    , .rx(rx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic rchk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    sel = 1'b1; addr = a; rstrb = 1'b1;
    #1;
    chk(tag, rdata, exp);
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wmask = 4'hF;
    @(negedge clk);
    sel = 1'b0; wmask = 4'h0;
  endtask

  task automatic burst(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sel = 1'b1; addr = 2'd0; wdata = 32'(first) + 32'(i); wmask = 4'hF;
    end
    @(negedge clk);
    sel = 1'b0; wmask = 4'h0;
  endtask

  // Cycle c is sampled at the negedge after the (c+1)th edge following the first push;
  // the first bit lasts div0 clocks, every other bit div clocks.
  task automatic check_frames(input int n, input int div0, input int div, input int start, input int inj);
    int ce, f, k, len;
    logic e;
    len = div0 + n * 10 * div - div;
    for (int c = start; c < len; c++) begin
      if (c != start) @(negedge clk);
      if (c == inj) begin sel = 1'b1; addr = 2'd0; wdata = 32'h47; wmask = 4'hF; end
      if (c == inj + 1) begin sel = 1'b0; wmask = 4'h0; end
      ce = (c < div0) ? 0 : c - div0 + div;
      f  = ce / (10 * div);
      k  = (ce % (10 * div)) / div;
      e  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fb[f][k-1];
      chk($sformatf("tx f%0d bit%0d c%0d", f, k, c), {31'b0, tx}, {31'b0, e});
    end
  endtask

`ifdef UART_IO_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      repeat (8) @(negedge clk);
    end
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1; sel = 1'b0; rstrb = 1'b0; addr = 2'd0; wdata = '0; wmask = 4'h0;
`ifdef UART_IO_RX_EN
    rx = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset irq", {31'b0, irq}, 32'd0);
    peek(2'd1, 32'h1, "reset STATUS");
    peek(2'd2, 32'd868, "reset DIV");
    peek(2'd3, 32'h0, "reset LEVEL");
    reset = 1'b0;
    rchk(2'd1, 32'h1, "post-reset STATUS");
`ifndef UART_IO_RX_EN
    rchk(2'd0, 32'h0, "DATA read no rx");
`endif
    repeat (2) @(negedge clk);
    chk("idle irq", {31'b0, irq}, 32'd1);

    // Single 0x55 frame at DIV=4
    wr(2'd2, 32'd4);
    rchk(2'd2, 32'd4, "DIV=4");
    fb[0] = 8'h55;
    burst(1, 8'h55);
    chk("tx before fall", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check_frames(1, 4, 4, 0, -10);
    rchk(2'd1, 32'h1, "STATUS after 0x55");
    chk("irq after 0x55", {31'b0, irq}, 32'd1);

    // Six back-to-back writes into a 4-deep FIFO; a seventh lands while full but popping
    fb[0] = 8'h41; fb[1] = 8'h42; fb[2] = 8'h43; fb[3] = 8'h44; fb[4] = 8'h45; fb[5] = 8'h47;
    burst(6, 8'h41);
    peek(2'd1, 32'h206, "STATUS full+ovf");
    peek(2'd3, 32'h4, "LEVEL full");
    chk("irq busy", {31'b0, irq}, 32'd0);
    check_frames(6, 4, 4, 4, 39);
    rchk(2'd1, 32'h5, "STATUS ovf sticky");
    wr(2'd1, 32'h3B);
    rchk(2'd1, 32'h5, "ovf kept");
    wr(2'd1, 32'h4);
    rchk(2'd1, 32'h1, "ovf cleared");

    // Divisor clamp and mid-frame change
    wr(2'd2, 32'd1);
    rchk(2'd2, 32'd4, "DIV clamp");
    fb[0] = 8'h0F;
    burst(1, 8'h0F);
    chk("tx before fall 2", {31'b0, tx}, 32'd1);
    @(negedge clk);
    sel = 1'b1; addr = 2'd2; wdata = 32'd10; wmask = 4'hF;
    chk("start bit", {31'b0, tx}, 32'd0);
    @(negedge clk);
    sel = 1'b0; wmask = 4'h0;
    check_frames(1, 4, 10, 1, -10);
    rchk(2'd2, 32'd10, "DIV=10");
    wr(2'd2, 32'd4);

    // Reset during the third data bit with three bytes queued
    burst(4, 8'h30);
    repeat (11) @(negedge clk);
    chk("tx data bit2", {31'b0, tx}, 32'd0);
    peek(2'd3, 32'h3, "LEVEL 3 queued");
    reset = 1'b1;
    #1;
    chk("tx on reset", {31'b0, tx}, 32'd1);
    chk("irq on reset", {31'b0, irq}, 32'd0);
    peek(2'd3, 32'h0, "LEVEL in reset");
    peek(2'd1, 32'h1, "STATUS in reset");
    peek(2'd2, 32'd868, "DIV in reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("tx idle after reset %0d", i), {31'b0, tx}, 32'd1);
    end
    rchk(2'd3, 32'h0, "LEVEL after reset");
    rchk(2'd1, 32'h1, "STATUS after reset");

`ifdef UART_IO_RX_EN
    wr(2'd2, 32'd8);
    send_rx(8'hA3, 1'b1);
    rchk(2'd1, 32'h9, "rx_valid");
    chk("irq rx", {31'b0, irq}, 32'd1);
    rchk(2'd3, 32'h100, "LEVEL rx");
    rchk(2'd0, 32'hA3, "DATA 0xA3");
    rchk(2'd1, 32'h1, "rx_valid cleared");
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rchk(2'd1, 32'h19, "rx_ovr");
    send_rx(8'h5A, 1'b0);
    rchk(2'd1, 32'h39, "rx_ferr");
    rchk(2'd0, 32'h11, "old byte kept");
    rchk(2'd1, 32'h31, "valid cleared stickies kept");
    wr(2'd1, 32'h30);
    rchk(2'd1, 32'h1, "rx stickies cleared");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
